z80_io_initiator: RTL and testbench

- Synthesizable Z80 I/O bus master. It is the initiating end of the same CPU port protocol that cpu_io answers: it drives A, iorq_n, rd_n, wr_n and the data bus, and samples wait_n and read data.
- Used as the on-board self-test and bring-up driver for VDP ports, and as the bench stimulus for cpu_io.
- A simple valid/ready request channel produces cycle-accurate T1/T2/TW/T3 I/O cycles. Each completed cycle returns one response pulse.

---
 rtl/z80_bus_pkg.sv | 15 +
 rtl/z80_io_initiator_if.sv | 30 +++
 rtl/z80_tstate_timer.sv | 30 +++
 rtl/z80_io_initiator.sv | 158 +++++++++++++++
 tb/tb_z80_io_initiator.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 I/O bus initiator.
package z80_bus_pkg;

    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} z80_io_state_t;

    // The Z80 always inserts one automatic wait state on I/O cycles.
    localparam int unsigned Z80_IO_AUTO_WAIT = 1;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } z80_io_req_t;

endpackage

// File: rtl/z80_io_initiator_if.sv
// Request/response channel plus Z80 I/O bus pins of the initiator.
interface z80_io_initiator_if;

    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [7:0] A;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] cd_out;
    logic       cd_oe;
    logic [7:0] cd_in;
    logic       wait_n;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, cd_in, wait_n,
        output req_ready, rsp_valid, rsp_rdata, A, iorq_n, rd_n, wr_n, cd_out, cd_oe
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, cd_in, wait_n,
        input  req_ready, rsp_valid, rsp_rdata, A, iorq_n, rd_n, wr_n, cd_out, cd_oe
    );

endinterface

// File: rtl/z80_tstate_timer.sv
// Divides the clock into T-states; last_tick marks the final clk of each T-state.
module z80_tstate_timer #(
    parameter int unsigned CLKS_PER_T = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic restart,
    output logic last_tick
);

    localparam int unsigned TickW = (CLKS_PER_T > 1) ? $clog2(CLKS_PER_T) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(CLKS_PER_T - 1);

    logic [TickW-1:0] tick_q;

    assign last_tick = enable && (tick_q == TickLast);

    // Wrapping on last_tick lets a repeated TW state time a fresh T-state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q <= '0;
        end else if (restart || last_tick || !enable) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + 1'b1;
        end
    end

endmodule

// File: rtl/z80_io_initiator.sv
// Z80 I/O bus master: turns valid/ready requests into T1/T2/TW/T3 IN/OUT cycles.
module z80_io_initiator
    import z80_bus_pkg::*;
#(
    parameter int unsigned CLKS_PER_T  = 4,
    parameter int unsigned WAIT_STATES = Z80_IO_AUTO_WAIT
) (
    input logic                clk,
    input logic                reset,
    z80_io_initiator_if.master bus
);

    localparam int unsigned WaitW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    z80_io_state_t    state_q, state_d;
    z80_io_req_t      req_q, req_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic [7:0]       a_q, a_d;
    logic             iorq_n_q, iorq_n_d;
    logic             rd_n_q, rd_n_d;
    logic             wr_n_q, wr_n_d;
    logic [7:0]       cd_out_q, cd_out_d;
    logic             cd_oe_q, cd_oe_d;
    logic             last_tick;
    logic             restart;
    logic             waits_done;

    z80_tstate_timer #(
        .CLKS_PER_T(CLKS_PER_T)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .enable   (state_q != IDLE),
        .restart  (restart),
        .last_tick(last_tick)
    );

    // True while finishing the last mandatory TW (or any TW once they are all done).
    assign waits_done = (32'(wait_q) + 32'd1 >= WAIT_STATES);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        wait_d      = wait_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        a_d         = a_q;
        iorq_n_d    = iorq_n_q;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        cd_out_d    = cd_out_q;
        cd_oe_d     = cd_oe_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_d   = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
                    state_d = T1;
                    a_d     = bus.req_addr;
                    if (bus.req_write) begin
                        cd_out_d = bus.req_wdata;
                        cd_oe_d  = 1'b1;
                    end
                end
            end
            T1: begin
                if (last_tick) begin
                    state_d  = T2;
                    iorq_n_d = 1'b0;
                    rd_n_d   = req_q.write;
                    wr_n_d   = !req_q.write;
                end
            end
            T2: begin
                if (last_tick) begin
                    state_d = (WAIT_STATES > 0 || !bus.wait_n) ? TW : T3;
                end
            end
            TW: begin
                if (last_tick) begin
                    if (waits_done && bus.wait_n) begin
                        state_d = T3;
                    end else if (!waits_done) begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
            T3: begin
                if (last_tick) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = req_q.write ? 8'h00 : bus.cd_in;
                    iorq_n_d    = 1'b1;
                    rd_n_d      = 1'b1;
                    wr_n_d      = 1'b1;
                    cd_oe_d     = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        restart = (state_d != state_q);
        if (restart) begin
            wait_d = '0;
        end
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wait_q  <= wait_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            a_q         <= 8'h00;
            iorq_n_q    <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            cd_out_q    <= 8'h00;
            cd_oe_q     <= 1'b0;
        end else begin
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            a_q         <= a_d;
            iorq_n_q    <= iorq_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            cd_out_q    <= cd_out_d;
            cd_oe_q     <= cd_oe_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.A         = a_q;
    assign bus.iorq_n    = iorq_n_q;
    assign bus.rd_n      = rd_n_q;
    assign bus.wr_n      = wr_n_q;
    assign bus.cd_out    = cd_out_q;
    assign bus.cd_oe     = cd_oe_q;

endmodule

// File: tb/tb_z80_io_initiator.sv
// Random request/wait traffic against a T-state-counting reference model, plus a WAIT_STATES=0 read.
module tb_z80_io_initiator;
    import z80_bus_pkg::*;

    localparam int CPT = 4;
    localparam int WS  = 1;

    logic clk;
    logic reset;

    z80_io_initiator_if bus ();
    z80_io_initiator_if bus0 ();

    z80_io_initiator #(
        .CLKS_PER_T (CPT),
        .WAIT_STATES(WS)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    z80_io_initiator #(
        .CLKS_PER_T (4),
        .WAIT_STATES(0)
    ) u_dut0 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus0.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position inside the current I/O cycle, counted in clks.
    bit          m_busy;
    int          m_k;
    bit          m_t3;
    z80_io_req_t m_req;
    bit          m_rsp;
    logic [7:0]  m_rdata;
    logic [7:0]  m_a;
    logic [7:0]  m_cd_out;
    int          n_resets = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_k      = 0;
        m_t3     = 1'b0;
        m_req    = '0;
        m_rsp    = 1'b0;
        m_rdata  = 8'h00;
        m_a      = 8'h00;
        m_cd_out = 8'h00;
    endtask

    task automatic check_outputs();
        bit strobe;
        strobe = m_busy && ((m_k - 1) / CPT >= 1);
        check("req_ready", bus.req_ready, !m_busy);
        check("rsp_valid", bus.rsp_valid, m_rsp);
        check("rsp_rdata", bus.rsp_rdata, m_rdata);
        check("A", bus.A, m_a);
        check("iorq_n", bus.iorq_n, !strobe);
        check("rd_n", bus.rd_n, !(strobe && !m_req.write));
        check("wr_n", bus.wr_n, !(strobe && m_req.write));
        check("cd_oe", bus.cd_oe, m_busy && m_req.write);
        check("cd_out", bus.cd_out, m_cd_out);
    endtask

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic step_model();
        int ts;
        m_rsp = 1'b0;
        if (!m_busy) begin
            if (bus.req_valid) begin
                m_busy      = 1'b1;
                m_k         = 1;
                m_t3        = 1'b0;
                m_req.write = bus.req_write;
                m_req.addr  = bus.req_addr;
                m_req.wdata = bus.req_wdata;
                m_a         = bus.req_addr;
                if (bus.req_write) m_cd_out = bus.req_wdata;
            end
        end else begin
            if (m_k % CPT == 0) begin
                ts = (m_k - 1) / CPT;
                if (m_t3) begin
                    m_busy  = 1'b0;
                    m_rsp   = 1'b1;
                    m_rdata = m_req.write ? 8'h00 : bus.cd_in;
                end else if (ts >= WS + 1 && bus.wait_n) begin
                    m_t3 = 1'b1;
                end
            end
            m_k++;
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = 8'h00;
        bus.req_wdata  = 8'h00;
        bus.cd_in      = 8'h00;
        bus.wait_n     = 1'b1;
        bus0.req_valid = 1'b0;
        bus0.req_write = 1'b0;
        bus0.req_addr  = 8'h00;
        bus0.req_wdata = 8'h00;
        bus0.cd_in     = 8'h00;
        bus0.wait_n    = 1'b1;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        reset = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (n_resets < 2 && cyc > 1000 * (n_resets + 1) && m_busy && m_req.write &&
                ((m_k - 1) / CPT >= 1)) begin
                // Mid-write reset: strobes and cd_oe must drop without waiting for a clock.
                reset = 1'b1;
                #1;
                check("rst_iorq_n", bus.iorq_n, 1);
                check("rst_wr_n", bus.wr_n, 1);
                check("rst_cd_oe", bus.cd_oe, 0);
                check("rst_req_ready", bus.req_ready, 1);
                model_reset();
                n_resets++;
                bus.req_valid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                check_outputs();
            end else begin
                bus.req_valid = ($urandom_range(3) != 0);
                bus.req_write = ($urandom_range(1) != 0);
                bus.req_addr  = 8'($urandom);
                bus.req_wdata = 8'($urandom);
                bus.wait_n    = ($urandom_range(3) != 0);
                bus.cd_in     = 8'($urandom);
                step_model();
                @(posedge clk);
                @(negedge clk);
                check_outputs();
            end
        end
        bus.req_valid = 1'b0;

        // WAIT_STATES=0 read: strobes low for clks 5..12, rsp_valid at clk 13.
        bus0.req_write = 1'b0;
        bus0.req_addr  = 8'h99;
        bus0.cd_in     = 8'h3C;
        bus0.wait_n    = 1'b1;
        bus0.req_valid = 1'b1;
        check("v0_ready", bus0.req_ready, 1);
        @(posedge clk);
        #1 bus0.req_valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check("v0_rd_n", bus0.rd_n, (k >= 5 && k <= 12) ? 0 : 1);
            check("v0_iorq_n", bus0.iorq_n, (k >= 5 && k <= 12) ? 0 : 1);
            check("v0_wr_n", bus0.wr_n, 1);
            check("v0_cd_oe", bus0.cd_oe, 0);
            check("v0_rsp_valid", bus0.rsp_valid, (k == 13) ? 1 : 0);
            if (k == 13) check("v0_rsp_rdata", bus0.rsp_rdata, 8'h3C);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
